// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner: frame-synchronous value loading,
// leading-zero blanking, optional hex glyphs, per-digit blink, anode dead time.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 128,
    parameter bit          HEX_EN       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    done_q, done_d;

    logic                    slot_tick, wrap, all_zero;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   lz_vec, blank_vec;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = HEX_EN ? 7'b0001000 : 7'b1111111;
            4'hB:    decode = HEX_EN ? 7'b0000011 : 7'b1111111;
            4'hC:    decode = HEX_EN ? 7'b1000110 : 7'b1111111;
            4'hD:    decode = HEX_EN ? 7'b0100001 : 7'b1111111;
            4'hE:    decode = HEX_EN ? 7'b0000110 : 7'b1111111;
            default: decode = HEX_EN ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    // Scan timing, load staging and blink phase
    always_comb begin
        slot_tick = (presc_q == PRE_LAST);
        wrap      = slot_tick && (idx_q == IDX_LAST);
        presc_d   = slot_tick ? '0 : presc_q + PW'(1);
        idx_d     = idx_q;
        staging_d = load ? digits_in : staging_q;
        active_d  = active_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        done_d    = wrap;
        if (wrap) begin
            idx_d    = '0;
            active_d = load ? digits_in : staging_q;
            if (frame_q == FRM_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end else if (slot_tick) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Leading-zero run scanned from the top slot down; slot 0 never joins it
    always_comb begin
        all_zero = 1'b1;
        lz_vec   = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            all_zero = all_zero & (active_q[4*(NUM_DIGITS-i) +: 4] == 4'd0);
            lz_vec[NUM_DIGITS-i] = all_zero;
        end
    end

    always_comb begin
        blank_vec = (lz_vec & {NUM_DIGITS{blank_lz}})
                  | (blink_mask & {NUM_DIGITS{~phase_q}});
        nibble    = active_q[{idx_q, 2'b00} +: 4];
        seg_d     = blank_vec[idx_q] ? 7'b1111111 : decode(nibble);
        an_d      = '1;
        if (presc_q != '0) begin
            an_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            active_q  <= '0;
            frame_q   <= '0;
            phase_q   <= 1'b1;
            seg_q     <= '1;
            an_q      <= '1;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            active_q  <= active_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            done_q    <= done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: HEX_EN=0 and HEX_EN=1 instances share
// stimulus; per-frame expectations are queued at each wrap and popped per cycle.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        reset, load, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
        .blank_lz(blank_lz), .blink_mask(blink_mask),
        .seg(seg0), .an(an0), .frame_done(fd0));

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
        .blank_lz(blank_lz), .blink_mask(blink_mask),
        .seg(seg1), .an(an1), .frame_done(fd1));

    typedef struct {
        logic [6:0] s0;
        logic [6:0] s1;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          frame_no = 0;
    int          m_cyc, wraps;
    logic        m_wrap;
    logic [15:0] m_stg, m_act;

    function automatic logic [6:0] glyph(input logic [3:0] v, input bit hex);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return hex ? 7'b0001000 : 7'b1111111;
            4'hB: return hex ? 7'b0000011 : 7'b1111111;
            4'hC: return hex ? 7'b1000110 : 7'b1111111;
            4'hD: return hex ? 7'b0100001 : 7'b1111111;
            4'hE: return hex ? 7'b0000110 : 7'b1111111;
            default: return hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; load is a single-cycle strobe, and the bench tracks its own
    // view of staging/active and wrap timing from the stimulus it applied.
    task automatic tick();
        logic        cl, cr;
        logic [15:0] cd;
        cl = load;
        cr = reset;
        cd = digits_in;
        @(negedge clk);
        load = 1'b0;
        if (cr) begin
            m_stg = '0; m_act = '0; m_cyc = 0; wraps = 0; m_wrap = 1'b0;
        end else begin
            m_cyc++;
            m_wrap = (m_cyc % FRAME) == 0;
            if (m_wrap) begin
                wraps++;
                m_act = cl ? cd : m_stg;
            end
            if (cl) m_stg = cd;
        end
    endtask

    task automatic drive_load(input logic [15:0] v);
        load      = 1'b1;
        digits_in = v;
    endtask

    task automatic wait_frame();
        while (!m_wrap) tick();
    endtask

    task automatic push_frame();
        exp_t e;
        bit   vis, blank;
        int   s;
        vis = ((wraps / BF) % 2) == 0;
        for (int j = 0; j < FRAME; j++) begin
            s     = j / SD;
            blank = (blank_lz && s > 0 && (m_act >> (4 * s)) == 16'h0)
                 || (blink_mask[s] && !vis);
            e.s0  = blank ? 7'b1111111 : glyph(m_act[4*s +: 4], 1'b0);
            e.s1  = blank ? 7'b1111111 : glyph(m_act[4*s +: 4], 1'b1);
            e.an  = (j % SD == 0) ? 4'b1111 : ~(4'b0001 << s);
            e.fd  = (j == FRAME - 1);
            sb.push_back(e);
        end
    endtask

    // Check one whole frame, optionally strobing load after sample index l1/l2.
    task automatic observe_frame(input int l1, input logic [15:0] v1,
                                 input int l2, input logic [15:0] v2);
        exp_t e;
        wait_frame();
        frame_no++;
        chk($sformatf("f%0d wrap_fd0", frame_no), fd0, 1);
        chk($sformatf("f%0d wrap_fd1", frame_no), fd1, 1);
        push_frame();
        for (int j = 0; j < FRAME; j++) begin
            tick();
            e = sb.pop_front();
            chk($sformatf("f%0d j%0d seg_hex0", frame_no, j), seg0, e.s0);
            chk($sformatf("f%0d j%0d seg_hex1", frame_no, j), seg1, e.s1);
            chk($sformatf("f%0d j%0d an", frame_no, j), an0, e.an);
            chk($sformatf("f%0d j%0d fd", frame_no, j), fd0, e.fd);
            if (j == l1) drive_load(v1);
            if (j == l2) drive_load(v2);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; blank_lz = 1'b0;
        digits_in = '0; blink_mask = '0;

        tick();
        chk("rst seg0", seg0, 7'h7f);
        chk("rst seg1", seg1, 7'h7f);
        chk("rst an0", an0, 4'hf);
        chk("rst an1", an1, 4'hf);
        chk("rst fd", fd0, 0);
        tick();
        reset = 1'b0;

        // basic decode; first wrap lands FRAME cycles after reset release
        drive_load(16'h1234);
        observe_frame(-1, '0, -1, '0);

        // leading-zero blanking
        blank_lz = 1'b1;
        drive_load(16'h0070);
        tick();
        observe_frame(-1, '0, -1, '0);
        drive_load(16'h0000);
        tick();
        observe_frame(-1, '0, -1, '0);

        // hex glyphs versus blanked codes
        blank_lz = 1'b0;
        drive_load(16'hABCF);
        tick();
        observe_frame(-1, '0, -1, '0);

        // mid-frame loads (last wins), then a load coincident with the wrap
        observe_frame(3, 16'h1111, 10, 16'h2222);
        observe_frame(FRAME - 2, 16'h5678, -1, '0);
        observe_frame(-1, '0, -1, '0);

        // blink slot 0 across two full phases
        blink_mask = 4'b0001;
        repeat (4) observe_frame(-1, '0, -1, '0);
        blink_mask = 4'b0000;

        // reset during slot 2 with a staged load pending
        drive_load(16'h9999);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        chk("midrst seg0", seg0, 7'h7f);
        chk("midrst seg1", seg1, 7'h7f);
        chk("midrst an", an0, 4'hf);
        chk("midrst fd", fd0, 0);
        reset = 1'b0;
        observe_frame(-1, '0, -1, '0);
        blank_lz = 1'b1;
        observe_frame(-1, '0, -1, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed N-digit seven-segment driver for the chronometer display path: scans one digit slot at a time, decodes a 4-bit value to active-low segments, and drives active-low digit enables. It extends single-digit decoding with:
- frame-synchronous, tear-free value loading
- leading-zero blanking
- optional hexadecimal glyphs
- per-digit blinking

It sits between the chronometer counter logic and the board's shared segment/anode pins.

## Interface
- NUM_DIGITS, 4: digit slots scanned; range 2..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLINK_FRAMES, 128: full scan frames per blink half-period; must be at least 1.
- HEX_EN, 0: 1 shows codes 10-15 as A b C d E F; 0 blanks them.
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  packed digit values; nibble i drives slot i; slot 0 is least significant.
- load  in  1  one-cycle strobe; captures digits_in for display from the next frame.
- blank_lz  in  1  when 1, leading zeros are blanked; sampled live.
- blink_mask  in  NUM_DIGITS  bit i=1 makes slot i blink; sampled live.
- seg  out  7  active-low segments, bit 6 = g ... bit 0 = a; registered.
- an  out  NUM_DIGITS  active-low digit enables; one-hot-low or all-high; registered.
- frame_done  out  1  one-cycle pulse on the cycle the scan wraps from slot NUM_DIGITS-1 to slot 0.

## Operation
- Registers:
  - prescaler: 0..SCAN_DIV-1
  - idx: 0..NUM_DIGITS-1
  - staging: 4*NUM_DIGITS bits
  - active: 4*NUM_DIGITS bits
  - frame_cnt: 0..BLINK_FRAMES-1
  - phase: 1 = visible
- Prescaler behaviour: increments every cycle. At SCAN_DIV-1 it returns to 0 and idx advances. This is the slot tick.
- Wrap: a slot tick while idx=NUM_DIGITS-1 is a wrap, and idx returns to 0.
- Load:
  - load=1 writes digits_in into staging. With several loads before a wrap, the last one wins.
  - At each wrap, active takes digits_in if load=1 in that same cycle; otherwise it takes staging.
  - active never changes mid-frame.
- Blink:
  - At each wrap, frame_cnt increments.
  - At BLINK_FRAMES-1, frame_cnt returns to 0 and phase toggles.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - With HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - With HEX_EN=0: codes 10-15 give 1111111.
- Leading-zero blanking: with blank_lz=1, slot k is blanked when every nibble of active from slot NUM_DIGITS-1 down to slot k is 0 and k>0. Slot 0 is never blanked, so value 0 shows a single "0".
- Blink blanking: slot k is blanked when blink_mask[k]=1 and phase=0.
- Blanked slot output: seg=1111111, and an still selects the slot.
- Dead time: on the first cycle of every slot (prescaler=0), an=all 1. For the remaining SCAN_DIV-1 cycles, an has bit idx low only. This suppresses ghosting.

## Timing
- Reset values, applied on the first rising edge with reset=1:
  - seg=1111111, an=all 1, frame_done=0
  - prescaler=0, idx=0, staging=0, active=0
  - frame_cnt=0, phase=1
- Reset mid-frame discards any pending staged load.
- seg/an latency: one cycle after prescaler/idx. Registered outputs reflect the slot selected in the previous cycle. seg and an always change on the same edge.
- frame_done: asserts for exactly one cycle, in the same cycle active updates and idx returns to 0.
- First wrap after reset: occurs NUM_DIGITS*SCAN_DIV cycles after reset deasserts.
- Live inputs: blank_lz and blink_mask changes take effect on the next output register update. They are not frame-synchronised.
- Simultaneous events: load at a wrap updates active immediately; the staging path is bypassed for that cycle.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset then load digits_in=0x1234 -> after the first wrap, slots 0..3 show 4,3,2,1: seg 0011001, 0110000, 0100100, 1111001 with an 1110, 1101, 1011, 0111. Each slot's first cycle has an=1111.
- blank_lz=1, load 0x0070 -> slot 3 and slot 2 blank (seg=1111111); slot 1=1111000; slot 0=1000000. Then load 0x0000 -> only slot 0 shows 1000000.
- HEX_EN=0 vs HEX_EN=1 builds, load 0xABCF -> slot 0 shows 1111111 (HEX_EN=0) versus 0001110 (HEX_EN=1). Slot 3 shows 1111111 versus 0001000.
- Load 0x1111 mid-frame, then load 0x2222 before the wrap -> the current frame still shows the previous active value. After the next frame_done, all slots show 0100100.
- blink_mask=0001 -> slot 0 is visible for 2 frames, blank for 2 frames, and repeats. Other slots are unaffected.
- Assert reset during slot 2 with a load pending -> next cycle gives seg=1111111 and an=1111. Afterwards active=0 and the display shows 0000, or only slot 0 with blank_lz=1.
